accel_dispatch_queue: RTL and testbench

Buffers predecoded accelerator (vector) instructions and their scalar operands between CVA6 issue and the Ara request interface. An instruction is sent to the accelerator only after the scoreboard commits it. The block tracks in-flight requests and returns accelerator responses to scalar writeback. It sits directly downstream of the first-pass accelerator decoder and issue-stage operand read.

---
 rtl/accel_dispatch_queue.sv | 158 +++++++++++++++
 tb/tb_accel_dispatch_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_dispatch_queue.sv
// Commit-gated dispatch queue between CVA6 issue and the Ara request interface.
// Optional stall performance counter is enabled by defining ACCEL_DISPATCH_PERF_EN.
module accel_dispatch_queue #(
   parameter int unsigned Depth       = 4,
   parameter int unsigned TransIdBits = 3,
   parameter int unsigned XLEN        = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [31:0]            req_insn_i,
   input  logic [XLEN-1:0]        req_rs1_i,
   input  logic [XLEN-1:0]        req_rs2_i,
   input  logic [TransIdBits-1:0] req_trans_id_i,
   input  logic                   commit_i,
   output logic                   acc_req_valid_o,
   input  logic                   acc_req_ready_i,
   output logic [31:0]            acc_insn_o,
   output logic [XLEN-1:0]        acc_rs1_o,
   output logic [XLEN-1:0]        acc_rs2_o,
   output logic [TransIdBits-1:0] acc_trans_id_o,
   input  logic                   acc_resp_valid_i,
   input  logic [XLEN-1:0]        acc_resp_result_i,
   input  logic [TransIdBits-1:0] acc_resp_trans_id_i,
   input  logic                   acc_resp_error_i,
   output logic                   wb_valid_o,
   output logic [XLEN-1:0]        wb_result_o,
   output logic [TransIdBits-1:0] wb_trans_id_o,
   output logic                   wb_exception_o,
   output logic                   idle_o,
   output logic [31:0]            stall_cycles_o
);

   localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned PtrW = IdxW + 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   typedef struct packed {
      logic [31:0]            insn;
      logic [XLEN-1:0]        rs1;
      logic [XLEN-1:0]        rs2;
      logic [TransIdBits-1:0] trans_id;
   } entry_t;

   entry_t mem_q [Depth];
   entry_t wr_entry;

   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] commit_q, commit_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] outst_q, outst_d;

   logic                   wb_valid_q;
   logic [XLEN-1:0]        wb_result_q;
   logic [TransIdBits-1:0] wb_trans_id_q;
   logic                   wb_exception_q;

   logic full;
   logic enq;
   logic issue;
   logic resp_accept;
   logic [IdxW-1:0] head_idx;

   // Pointers carry a wrap bit: full when indices match but wrap bits differ.
   assign full        = (head_q[PtrW-1] != tail_q[PtrW-1]) &&
                        (head_q[IdxW-1:0] == tail_q[IdxW-1:0]);
   assign req_ready_o = !full && !flush_i;
   assign enq         = req_valid_i && req_ready_o;

   assign acc_req_valid_o = (head_q != commit_q) && (outst_q < CntW'(Depth));
   assign issue           = acc_req_valid_o && acc_req_ready_i;
   assign resp_accept     = acc_resp_valid_i && (outst_q != '0);

   assign head_idx       = head_q[IdxW-1:0];
   assign acc_insn_o     = mem_q[head_idx].insn;
   assign acc_rs1_o      = mem_q[head_idx].rs1;
   assign acc_rs2_o      = mem_q[head_idx].rs2;
   assign acc_trans_id_o = mem_q[head_idx].trans_id;

   assign idle_o = (head_q == tail_q) && (outst_q == '0);

   assign wr_entry = '{insn: req_insn_i, rs1: req_rs1_i, rs2: req_rs2_i,
                       trans_id: req_trans_id_i};

   // Next-state for pointers and outstanding count; commit resolves before flush.
   always_comb begin
      head_d   = head_q;
      commit_d = commit_q;
      tail_d   = tail_q;
      outst_d  = outst_q;
      if (enq) tail_d = tail_q + PtrW'(1);
      if (commit_i && (commit_q != tail_q)) commit_d = commit_q + PtrW'(1);
      if (flush_i) tail_d = commit_d;
      if (issue) head_d = head_q + PtrW'(1);
      case ({issue, resp_accept})
         2'b10:   outst_d = outst_q + CntW'(1);
         2'b01:   outst_d = outst_q - CntW'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q         <= '0;
         commit_q       <= '0;
         tail_q         <= '0;
         outst_q        <= '0;
         wb_valid_q     <= 1'b0;
         wb_result_q    <= '0;
         wb_trans_id_q  <= '0;
         wb_exception_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         commit_q   <= commit_d;
         tail_q     <= tail_d;
         outst_q    <= outst_d;
         wb_valid_q <= resp_accept;
         if (resp_accept) begin
            wb_result_q    <= acc_resp_result_i;
            wb_trans_id_q  <= acc_resp_trans_id_i;
            wb_exception_q <= acc_resp_error_i;
         end
      end
   end

   // Payload storage needs no reset; pointers define which slots are live.
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[tail_q[IdxW-1:0]] <= wr_entry;
   end

   assign wb_valid_o     = wb_valid_q;
   assign wb_result_o    = wb_result_q;
   assign wb_trans_id_o  = wb_trans_id_q;
   assign wb_exception_o = wb_exception_q;

`ifdef ACCEL_DISPATCH_PERF_EN
   logic [31:0] stall_q, stall_d;

   // Saturating count of cycles the accelerator back-pressures a valid request.
   always_comb begin
      stall_d = stall_q;
      if (acc_req_valid_o && !acc_req_ready_i && (stall_q != '1))
         stall_d = stall_q + 32'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_accel_dispatch_queue.sv
// Directed self-checking bench for accel_dispatch_queue (Depth 4, 3-bit IDs, XLEN 64).
module tb_accel_dispatch_queue;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_insn_i;
   logic [63:0] req_rs1_i;
   logic [63:0] req_rs2_i;
   logic [2:0]  req_trans_id_i;
   logic        commit_i;
   logic        acc_req_valid_o;
   logic        acc_req_ready_i;
   logic [31:0] acc_insn_o;
   logic [63:0] acc_rs1_o;
   logic [63:0] acc_rs2_o;
   logic [2:0]  acc_trans_id_o;
   logic        acc_resp_valid_i;
   logic [63:0] acc_resp_result_i;
   logic [2:0]  acc_resp_trans_id_i;
   logic        acc_resp_error_i;
   logic        wb_valid_o;
   logic [63:0] wb_result_o;
   logic [2:0]  wb_trans_id_o;
   logic        wb_exception_o;
   logic        idle_o;
   logic [31:0] stall_cycles_o;

   int tests_run = 0;
   int tests_failed = 0;
   logic [2:0] got_q[$];

`ifdef ACCEL_DISPATCH_PERF_EN
   localparam logic [31:0] ExpStall = 32'd7;
`else
   localparam logic [31:0] ExpStall = 32'd0;
`endif

   accel_dispatch_queue #(.Depth(4), .TransIdBits(3), .XLEN(64)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_insn_i(req_insn_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
      .req_trans_id_i(req_trans_id_i), .commit_i(commit_i),
      .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
      .acc_insn_o(acc_insn_o), .acc_rs1_o(acc_rs1_o), .acc_rs2_o(acc_rs2_o),
      .acc_trans_id_o(acc_trans_id_o),
      .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_result_i(acc_resp_result_i),
      .acc_resp_trans_id_i(acc_resp_trans_id_i), .acc_resp_error_i(acc_resp_error_i),
      .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o),
      .wb_trans_id_o(wb_trans_id_o), .wb_exception_o(wb_exception_o),
      .idle_o(idle_o), .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_insn_i = '0;
      req_rs1_i = '0; req_rs2_i = '0; req_trans_id_i = '0; commit_i = 1'b0;
      acc_req_ready_i = 1'b0; acc_resp_valid_i = 1'b0; acc_resp_result_i = '0;
      acc_resp_trans_id_i = '0; acc_resp_error_i = 1'b0;
      cyc(); cyc();
      rst_i = 1'b0;
   endtask

   task automatic enq(input logic [2:0] id, input logic [31:0] insn,
                      input logic [63:0] rs1, input logic [63:0] rs2);
      req_valid_i = 1'b1; req_trans_id_i = id; req_insn_i = insn;
      req_rs1_i = rs1; req_rs2_i = rs2;
      cyc();
      req_valid_i = 1'b0;
   endtask

   // Runs for a fixed number of cycles, committing in the first ncommit, logging issued IDs.
   task automatic run_collect(input int cycles, input int ncommit);
      got_q.delete();
      for (int c = 0; c < cycles; c++) begin
         commit_i = (c < ncommit);
         if (acc_req_valid_o && acc_req_ready_i) got_q.push_back(acc_trans_id_o);
         cyc();
      end
      commit_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready_o); end
      tests_run++; if (acc_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_acc_valid got=%0b exp=0", acc_req_valid_o); end
      tests_run++; if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid_o); end
      tests_run++; if (wb_result_o !== 64'd0) begin tests_failed++; $display("FAIL reset_wb_result got=%0h exp=0", wb_result_o); end
      tests_run++; if (idle_o !== 1'b1) begin tests_failed++; $display("FAIL reset_idle got=%0b exp=1", idle_o); end
      tests_run++; if (stall_cycles_o !== 32'd0) begin tests_failed++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles_o); end
   endtask

   task automatic test_basic_flow();
      do_reset();
      acc_req_ready_i = 1'b1;
      enq(3'd2, 32'h0000_5057, 64'h11, 64'h22);
      commit_i = 1'b1;
      tests_run++; if (acc_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_n1 got=%0b exp=0", acc_req_valid_o); end
      cyc();
      commit_i = 1'b0;
      tests_run++; if (acc_req_valid_o !== 1'b1) begin tests_failed++; $display("FAIL basic_valid_n2 got=%0b exp=1", acc_req_valid_o); end
      tests_run++; if (acc_trans_id_o !== 3'd2) begin tests_failed++; $display("FAIL basic_id got=%0d exp=2", acc_trans_id_o); end
      tests_run++; if (acc_insn_o !== 32'h0000_5057) begin tests_failed++; $display("FAIL basic_insn got=%0h exp=5057", acc_insn_o); end
      tests_run++; if (acc_rs1_o !== 64'h11) begin tests_failed++; $display("FAIL basic_rs1 got=%0h exp=11", acc_rs1_o); end
      cyc();
      tests_run++; if (acc_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_after got=%0b exp=0", acc_req_valid_o); end
      tests_run++; if (idle_o !== 1'b0) begin tests_failed++; $display("FAIL basic_busy got=%0b exp=0", idle_o); end
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'h10; acc_resp_trans_id_i = 3'd2;
      cyc();
      acc_resp_valid_i = 1'b0;
      tests_run++; if (wb_valid_o !== 1'b1) begin tests_failed++; $display("FAIL basic_wb_valid got=%0b exp=1", wb_valid_o); end
      tests_run++; if (wb_result_o !== 64'h10) begin tests_failed++; $display("FAIL basic_wb_result got=%0h exp=10", wb_result_o); end
      tests_run++; if (wb_trans_id_o !== 3'd2) begin tests_failed++; $display("FAIL basic_wb_id got=%0d exp=2", wb_trans_id_o); end
      tests_run++; if (wb_exception_o !== 1'b0) begin tests_failed++; $display("FAIL basic_wb_exc got=%0b exp=0", wb_exception_o); end
      cyc();
      tests_run++; if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_wb_pulse got=%0b exp=0", wb_valid_o); end
      tests_run++; if (idle_o !== 1'b1) begin tests_failed++; $display("FAIL basic_idle got=%0b exp=1", idle_o); end
   endtask

   task automatic test_full();
      do_reset();
      acc_req_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) enq(3'(i), 32'h100 + 32'(i), 64'(i), 64'(i));
      tests_run++; if (req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL full_ready got=%0b exp=0", req_ready_o); end
      tests_run++; if (acc_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL full_valid got=%0b exp=0", acc_req_valid_o); end
      commit_i = 1'b1;
      cyc();
      commit_i = 1'b0;
      tests_run++; if (acc_req_valid_o !== 1'b1) begin tests_failed++; $display("FAIL full_issue_valid got=%0b exp=1", acc_req_valid_o); end
      tests_run++; if (req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL full_ready_during_issue got=%0b exp=0", req_ready_o); end
      cyc();
      tests_run++; if (req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL full_ready_freed got=%0b exp=1", req_ready_o); end
      enq(3'd4, 32'h104, 64'd4, 64'd4);
      run_collect(8, 3);
      tests_run++; if (got_q.size() !== 3) begin tests_failed++; $display("FAIL full_issue_count got=%0d exp=3", got_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         tests_run++; if (got_q[i] !== 3'(i + 1)) begin tests_failed++; $display("FAIL full_issue_order[%0d] got=%0d exp=%0d", i, got_q[i], i + 1); end
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 1; i <= 3; i++) enq(3'(i), 32'h200 + 32'(i), 64'(i), 64'(i));
      commit_i = 1'b1;
      cyc();
      flush_i = 1'b1;
      #1;
      tests_run++; if (req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL flush_ready got=%0b exp=0", req_ready_o); end
      cyc();
      commit_i = 1'b0; flush_i = 1'b0;
      tests_run++; if (acc_trans_id_o !== 3'd1) begin tests_failed++; $display("FAIL flush_head_id got=%0d exp=1", acc_trans_id_o); end
      enq(3'd6, 32'h206, 64'd6, 64'd6);
      acc_req_ready_i = 1'b1;
      run_collect(8, 1);
      tests_run++; if (got_q.size() !== 3) begin tests_failed++; $display("FAIL flush_issue_count got=%0d exp=3", got_q.size()); end
      if (got_q.size() == 3) begin
         tests_run++; if (got_q[0] !== 3'd1) begin tests_failed++; $display("FAIL flush_issue0 got=%0d exp=1", got_q[0]); end
         tests_run++; if (got_q[1] !== 3'd2) begin tests_failed++; $display("FAIL flush_issue1 got=%0d exp=2", got_q[1]); end
         tests_run++; if (got_q[2] !== 3'd6) begin tests_failed++; $display("FAIL flush_issue2 got=%0d exp=6", got_q[2]); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      enq(3'd5, 32'hABCD_0057, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002);
      commit_i = 1'b1;
      cyc();
      commit_i = 1'b0;
      for (int c = 0; c < 7; c++) begin
         tests_run++;
         if (acc_req_valid_o !== 1'b1 || acc_insn_o !== 32'hABCD_0057 || acc_trans_id_o !== 3'd5 ||
             acc_rs1_o !== 64'hDEAD_BEEF_0000_0001 || acc_rs2_o !== 64'hCAFE_F00D_0000_0002) begin
            tests_failed++;
            $display("FAIL stall_stable[%0d] got v=%0b insn=%0h id=%0d rs1=%0h rs2=%0h exp v=1 insn=abcd0057 id=5",
                     c, acc_req_valid_o, acc_insn_o, acc_trans_id_o, acc_rs1_o, acc_rs2_o);
         end
         cyc();
      end
      acc_req_ready_i = 1'b1;
      tests_run++; if (stall_cycles_o !== ExpStall) begin tests_failed++; $display("FAIL stall_count got=%0d exp=%0d", stall_cycles_o, ExpStall); end
      cyc();
      tests_run++; if (stall_cycles_o !== ExpStall) begin tests_failed++; $display("FAIL stall_count_hold got=%0d exp=%0d", stall_cycles_o, ExpStall); end
   endtask

   task automatic test_outstanding();
      do_reset();
      acc_req_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) enq(3'(i), 32'h300 + 32'(i), 64'(i), 64'(i));
      run_collect(8, 4);
      tests_run++; if (got_q.size() !== 4) begin tests_failed++; $display("FAIL outst_issue_count got=%0d exp=4", got_q.size()); end
      enq(3'd4, 32'h304, 64'd4, 64'd4);
      commit_i = 1'b1;
      cyc();
      commit_i = 1'b0;
      tests_run++; if (acc_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL outst_blocked got=%0b exp=0", acc_req_valid_o); end
      cyc();
      tests_run++; if (acc_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL outst_blocked2 got=%0b exp=0", acc_req_valid_o); end
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'h55; acc_resp_trans_id_i = 3'd0; acc_resp_error_i = 1'b1;
      cyc();
      acc_resp_valid_i = 1'b0; acc_resp_error_i = 1'b0;
      tests_run++; if (acc_req_valid_o !== 1'b1 || acc_trans_id_o !== 3'd4) begin tests_failed++; $display("FAIL outst_unblock got v=%0b id=%0d exp v=1 id=4", acc_req_valid_o, acc_trans_id_o); end
      tests_run++; if (wb_valid_o !== 1'b1 || wb_exception_o !== 1'b1 || wb_result_o !== 64'h55) begin tests_failed++; $display("FAIL outst_wb_err got v=%0b exc=%0b res=%0h exp v=1 exc=1 res=55", wb_valid_o, wb_exception_o, wb_result_o); end
      cyc();
      for (int i = 1; i <= 4; i++) begin
         acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'h60 + 64'(i); acc_resp_trans_id_i = 3'(i);
         cyc();
         tests_run++; if (wb_valid_o !== 1'b1 || wb_result_o !== 64'h60 + 64'(i) || wb_trans_id_o !== 3'(i)) begin tests_failed++; $display("FAIL outst_drain[%0d] got v=%0b res=%0h id=%0d exp v=1 res=%0h id=%0d", i, wb_valid_o, wb_result_o, wb_trans_id_o, 64'h60 + 64'(i), i); end
      end
      acc_resp_valid_i = 1'b0;
      cyc();
      tests_run++; if (idle_o !== 1'b1) begin tests_failed++; $display("FAIL outst_idle got=%0b exp=1", idle_o); end
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'h99; acc_resp_trans_id_i = 3'd7;
      cyc();
      acc_resp_valid_i = 1'b0;
      tests_run++; if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL outst_stray_resp got=%0b exp=0", wb_valid_o); end
      tests_run++; if (wb_result_o !== 64'h64) begin tests_failed++; $display("FAIL outst_stray_hold got=%0h exp=64", wb_result_o); end
   endtask

   task automatic test_midop_reset();
      do_reset();
      acc_req_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) enq(3'(i), 32'h400 + 32'(i), 64'(i), 64'(i));
      run_collect(6, 2);
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'h77; acc_resp_trans_id_i = 3'd1;
      cyc();
      acc_resp_valid_i = 1'b0;
      tests_run++; if (wb_result_o !== 64'h77 || idle_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_pre got res=%0h idle=%0b exp res=77 idle=0", wb_result_o, idle_o); end
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      tests_run++; if (req_ready_o !== 1'b1 || acc_req_valid_o !== 1'b0 || idle_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_ctrl got rdy=%0b v=%0b idle=%0b exp rdy=1 v=0 idle=1", req_ready_o, acc_req_valid_o, idle_o); end
      tests_run++; if (wb_valid_o !== 1'b0 || wb_result_o !== 64'd0 || wb_trans_id_o !== 3'd0 || wb_exception_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_wb got v=%0b res=%0h id=%0d exc=%0b exp all 0", wb_valid_o, wb_result_o, wb_trans_id_o, wb_exception_o); end
      tests_run++; if (stall_cycles_o !== 32'd0) begin tests_failed++; $display("FAIL midrst_stall got=%0d exp=0", stall_cycles_o); end
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'h88; acc_resp_trans_id_i = 3'd2;
      cyc();
      acc_resp_valid_i = 1'b0;
      tests_run++; if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_late_resp got=%0b exp=0", wb_valid_o); end
   endtask

   initial begin
      test_reset();
      test_basic_flow();
      test_full();
      test_flush();
      test_stall();
      test_outstanding();
      test_midop_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
